cos_core_scheduler: RTL and testbench

- Shares one taylor_horner_rtl cosine core between N_REQ requesters.
- Arbitrates round-robin among pending requests and latches the winner's angle.
- Sequences the core's start/ready protocol, then returns the fixed-point cosine tagged with the requester ID.
- Sits between the requesting datapath blocks and the single core instance.

---
 rtl/cos_core_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_cos_core_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cos_core_scheduler.sv
// Purpose: shares one cosine core between N_REQ requesters with round-robin arbitration.
// Latency: grant in T, core_start in T+1, resp_valid two cycles after the core_ready rising edge.
// Backpressure: one transaction in flight; no grant until the cycle after resp_ack.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   req_valid/req_angle  per-requester request and flattened angles (requester i at [i*DATA_W +: DATA_W])
//   req_ready            one-hot, single-cycle grant pulse; the angle is latched in that cycle
//   resp_valid/resp_id/resp_cos/resp_err/resp_ack  tagged response, held until acknowledged
//   core_start/core_angle/core_ready/core_cos      handshake with the shared cosine core
// Optional macro CORE_TIMEOUT_EN: watchdog of TIMEOUT_CYCLES in WAIT, returning resp_err=1, resp_cos=0.
module cos_core_scheduler #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 24,
    parameter int FRAC_W         = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_angle,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      resp_valid,
    output logic [$clog2(N_REQ)-1:0]  resp_id,
    output logic [DATA_W-1:0]         resp_cos,
    output logic                      resp_err,
    input  logic                      resp_ack,
    output logic                      core_start,
    output logic [DATA_W-1:0]         core_angle,
    input  logic                      core_ready,
    input  logic [DATA_W-1:0]         core_cos
);

    localparam int ID_W = $clog2(N_REQ);

    // Fixed-point format is only carried through; reject nonsensical configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || FRAC_W >= DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cos_core_scheduler: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic              core_ready_q;
    logic              ready_rise;
    logic [DATA_W-1:0] angle_arr [N_REQ];

    assign ready_rise = core_ready & ~core_ready_q;

`ifdef CORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            angle_arr[i] = req_angle[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: scan offsets from high to low so the smallest offset
    // from rr_ptr (the first pending requester at or after it) wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_l;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_l     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_l = ID_W'(idx);
            if (req_valid[idx_l]) begin
                grant_any = 1'b1;
                grant_id  = idx_l;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Grant is combinational on req_valid; mask it while reset is held.
                if (grant_any && !reset) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A level already high on entry is stale; only a fresh edge completes.
                if (ready_rise) begin
                    state_nxt = CAPTURE;
                end
`ifdef CORE_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = RESP;
                end
`endif
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            core_angle   <= '0;
            resp_id      <= '0;
            resp_cos     <= '0;
            core_ready_q <= 1'b0;
        end else begin
            core_ready_q <= core_ready;
            if (state == IDLE && grant_any) begin
                core_angle <= angle_arr[grant_id];
                resp_id    <= grant_id;
                rr_ptr     <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == CAPTURE) begin
                resp_cos <= core_cos;
            end
`ifdef CORE_TIMEOUT_EN
            if (state == WAIT && !ready_rise && timeout) begin
                resp_cos <= '0;
            end
`endif
        end
    end

`ifdef CORE_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            resp_err <= 1'b0;
        end else begin
            // Counter is zero on the first WAIT cycle and counts WAIT cycles only.
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == CAPTURE) begin
                resp_err <= 1'b0;
            end else if (state == WAIT && !ready_rise && timeout) begin
                resp_err <= 1'b1;
            end
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cos_core_scheduler.sv
// Purpose: randomized and directed bench for cos_core_scheduler against a transaction-timeline model.
// Latency: model predicts grant/start/response cycles from request, core edge and ack timing.
// Backpressure: consumer ack is randomized, with a directed 20-cycle hold.
module tb_cos_core_scheduler;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_angle = '0;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic [IW-1:0] resp_id;
    logic [W-1:0]  resp_cos;
    logic          resp_err;
    logic          resp_ack = 1'b0;
    logic          core_start;
    logic [W-1:0]  core_angle;
    logic          core_ready = 1'b0;
    logic [W-1:0]  core_cos = '0;

    always #5 clock = ~clock;

    cos_core_scheduler #(.N_REQ(N), .DATA_W(W), .FRAC_W(10), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_cos(resp_cos),
        .resp_err(resp_err), .resp_ack(resp_ack),
        .core_start(core_start), .core_angle(core_angle),
        .core_ready(core_ready), .core_cos(core_cos)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    // stimulus controls
    bit rst_cmd = 1'b1, hold_all = 1'b0, auto_req = 1'b0, clr_req = 1'b0;
    int core_mode = 0, fixed_lat = 10, ack_prob = 100, req_prob = 0;
    logic [N-1:0] inj = '0;
    logic [W-1:0] inj_ang [N];
    logic [N-1:0] granted_last = '0;

    // core model: 0 = latency c_lat, ready held until next start; 1 = stale level; 2 = never ready
    bit c_any = 1'b0;
    int c_t0 = 0, c_lat = 10;
    logic [W-1:0] c_ang = '0;

    // transaction-timeline model
    bit busy = 1'b0, exp_err = 1'b0, prev_ready = 1'b0, prev_rv = 1'b0;
    int exp_rr = 0, g_id = 0, t_grant = 0, t_resp = -1;
    logic [W-1:0] g_angle = '0, exp_cos = '0;

    // observation logs used by literal pins
    int dut_grants[$];
    logic [W-1:0] resp_log[$];
    int last_start = -1, resp_rise = -1, last_ack = -1, last_grant = -1;

    function automatic logic [W-1:0] cos_fn(input logic [W-1:0] a);
        // cos(0.5) in Q.10 is 0.8776*1024 ~= 898; everything else is angle+1
        return (a == 24'd512) ? 24'd898 : a + 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        reset = rst_cmd;
        for (int i = 0; i < N; i++) begin
            if (rst_cmd || clr_req) begin
                req_valid[i] = 1'b0;
            end else begin
                if (granted_last[i] && !hold_all) req_valid[i] = 1'b0;
                if (auto_req && req_valid[i] && $urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
                if (auto_req && !req_valid[i] && $urandom_range(0, 99) < req_prob) begin
                    req_valid[i] = 1'b1;
                    req_angle[i*W +: W] = W'($urandom);
                end
            end
            if (inj[i] && !rst_cmd) begin
                req_valid[i] = 1'b1;
                req_angle[i*W +: W] = inj_ang[i];
            end
        end
        inj = '0;
        clr_req = 1'b0;
        if (rst_cmd) begin
            core_ready = 1'b0;
            c_any = 1'b0;
        end else begin
            case (core_mode)
                0:       core_ready = c_any && (cyc >= c_t0 + c_lat);
                1:       core_ready = !c_any || (cyc < c_t0 + 3) || (cyc >= c_t0 + 10);
                default: core_ready = 1'b0;
            endcase
        end
        core_cos = cos_fn(c_ang);
        resp_ack = ($urandom_range(0, 99) < ack_prob);
    endtask

    task automatic check();
        logic [N-1:0] exp_rdy;
        bit v;
        int g;
        if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_core_start", core_start, 0);
            chk("rst_core_angle", core_angle, 0);
            chk("rst_resp_cos", resp_cos, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_resp_err", resp_err, 0);
            busy = 1'b0; exp_rr = 0; prev_ready = 1'b0; prev_rv = 1'b0; granted_last = '0;
            return;
        end
        // grant: first pending requester at or after the round-robin pointer
        exp_rdy = '0;
        if (!busy && req_valid != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(exp_rr + k) % N]) g = (exp_rr + k) % N;
            end
            exp_rdy[g] = 1'b1;
            busy = 1'b1; g_id = g; g_angle = req_angle[g*W +: W];
            t_grant = cyc; t_resp = -1; exp_rr = (g + 1) % N;
        end
        chk("req_ready", req_ready, exp_rdy);
        granted_last = req_ready;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                dut_grants.push_back(i);
                last_grant = cyc;
            end
        end
        chk("core_start", core_start, busy && cyc == t_grant + 1);
        if (core_start) begin
            c_any = 1'b1; c_t0 = cyc; c_ang = core_angle; last_start = cyc;
            c_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(2, 14);
        end
        if (busy && cyc > t_grant && (t_resp < 0 || cyc < t_resp))
            chk("core_angle", core_angle, g_angle);
        // completion: first rising edge of core_ready once waiting (from grant+2)
        if (busy && t_resp < 0 && cyc >= t_grant + 2) begin
            if (core_ready && !prev_ready) begin
                t_resp = cyc + 2; exp_err = 1'b0; exp_cos = cos_fn(g_angle);
            end
`ifdef CORE_TIMEOUT_EN
            else if (cyc == t_grant + 2 + TO) begin
                t_resp = cyc + 1; exp_err = 1'b1; exp_cos = '0;
            end
`endif
        end
        v = busy && t_resp >= 0 && cyc >= t_resp;
        chk("resp_valid", resp_valid, v);
        if (resp_valid && !prev_rv) resp_rise = cyc;
        prev_rv = resp_valid;
        if (v) begin
            chk("resp_id", resp_id, g_id);
            chk("resp_cos", resp_cos, exp_cos);
            chk("resp_err", resp_err, exp_err);
            if (resp_ack) begin
                busy = 1'b0; last_ack = cyc;
                resp_log.push_back(resp_cos);
            end
        end
        prev_ready = core_ready;
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        drive();
        #1;
        check();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        run(2);
        rst_cmd = 1'b0;
        dut_grants.delete();
        resp_log.delete();
    endtask

    task automatic wait_resp(input int limit, input string name);
        int k;
        int n0;
        k = 0;
        n0 = resp_log.size();
        while (resp_log.size() == n0 && k < limit) begin
            step();
            k++;
        end
        chk(name, resp_log.size() > n0, 1);
    endtask

    initial begin
        int k;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        run(3);
        rst_cmd = 1'b0;

        // single request: angle 0.5
        core_mode = 0; fixed_lat = 10; ack_prob = 100;
        inj[0] = 1'b1; inj_ang[0] = 24'd512;
        wait_resp(40, "t1_done");
        chk("t1_start_to_resp", resp_rise - last_start, 12);
        chk("t1_grant_to_resp", resp_rise - last_grant, 13);
        chk("t1_cos_range", (resp_log.size() > 0) && resp_log[0] >= 897 && resp_log[0] <= 900, 1);
        chk("t1_grant_id", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

        // round-robin with all four held
        do_reset();
        hold_all = 1'b1;
        for (int i = 0; i < N; i++) begin
            inj[i] = 1'b1; inj_ang[i] = W'(100 * (i + 1));
        end
        k = 0;
        while (dut_grants.size() < 5 && k < 200) begin step(); k++; end
        hold_all = 1'b0; clr_req = 1'b1;
        wait_resp(40, "t2_done");
        chk("t2_grants", dut_grants.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t2_order", (i < dut_grants.size()) ? dut_grants[i] : -1, exp_order[i]);
        chk("t2_cos0", (resp_log.size() > 0) ? resp_log[0] : '1, 101);
        chk("t2_cos3", (resp_log.size() > 3) ? resp_log[3] : '1, 401);

        // response backpressure
        do_reset();
        hold_all = 1'b1; ack_prob = 0;
        for (int i = 0; i < N; i++) begin
            inj[i] = 1'b1; inj_ang[i] = W'($urandom);
        end
        k = 0;
        while (!resp_valid && k < 40) begin step(); k++; end
        chk("t3_resp_seen", resp_valid, 1);
        run(20);
        chk("t3_no_grant_in_hold", dut_grants.size(), 1);
        ack_prob = 100;
        k = 0;
        while (dut_grants.size() < 2 && k < 10) begin step(); k++; end
        chk("t3_grant_after_ack", last_grant - last_ack, 1);
        hold_all = 1'b0; clr_req = 1'b1;
        wait_resp(40, "t3_done");

        // stale ready level
        do_reset();
        core_mode = 1;
        inj[3] = 1'b1; inj_ang[3] = 24'd777;
        wait_resp(40, "t4_done");
        chk("t4_start_to_resp", resp_rise - last_start, 12);
        chk("t4_cos", (resp_log.size() > 0) ? resp_log[0] : '1, 778);
        core_mode = 0;

        // asynchronous reset while waiting on the core
        do_reset();
        inj[2] = 1'b1; inj_ang[2] = 24'd50;
        run(6);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_resp_valid", resp_valid, 0);
        chk("t5_async_core_start", core_start, 0);
        chk("t5_async_core_angle", core_angle, 0);
        chk("t5_async_req_ready", req_ready, 0);
        do_reset();
        inj[1] = 1'b1; inj_ang[1] = 24'd11;
        inj[3] = 1'b1; inj_ang[3] = 24'd33;
        step();
        chk("t5_rr_restart", (dut_grants.size() > 0) ? dut_grants[0] : -1, 1);
        wait_resp(40, "t5_first");
        wait_resp(40, "t5_second");
        inj[2] = 1'b1; inj_ang[2] = 24'd222;
        wait_resp(40, "t5_req2");
        chk("t5_req2_cos", (resp_log.size() > 2) ? resp_log[2] : '1, 223);

`ifdef CORE_TIMEOUT_EN
        // watchdog: core never answers
        do_reset();
        core_mode = 2;
        inj[0] = 1'b1; inj_ang[0] = 24'd300;
        wait_resp(60, "t6_timeout");
        chk("t6_start_to_resp", resp_rise - last_start, TO + 2);
        chk("t6_cos_zero", (resp_log.size() > 0) ? resp_log[0] : '1, 0);
        core_mode = 0;
        inj[1] = 1'b1; inj_ang[1] = 24'd40;
        wait_resp(40, "t6_recover");
        chk("t6_recover_cos", (resp_log.size() > 1) ? resp_log[1] : '1, 41);
`endif

        // randomized traffic
        do_reset();
        auto_req = 1'b1; req_prob = 15; ack_prob = 60; fixed_lat = 0;
        run(1500);
        auto_req = 1'b0; clr_req = 1'b1; ack_prob = 100;
        run(40);
        chk("rand_progress", resp_log.size() >= 20, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
